// File: rtl/multicycle_main_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_main_fsm_if
// Control bundle between the multicycle main FSM and the datapath.
//   Op, Funct   : instruction fields from the instruction register
//   MemReady    : unified memory completes the current access this cycle
//   IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
//   RegW, MemW, Branch : per-cycle datapath enables / mux selects
//   Fault       : one-cycle pulse on memory timeout or undefined Op
//   State       : current FSM state code (debug)
// master = FSM side (drives control), slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_main_fsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemReady;
   logic       IRWrite;
   logic       NextPC;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       ALUOp;
   logic       RegW;
   logic       MemW;
   logic       Branch;
   logic       Fault;
   logic [3:0] State;

   modport master (
      input  Op, Funct, MemReady,
      output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             ALUOp, RegW, MemW, Branch, Fault, State
   );

   modport slave (
      output Op, Funct, MemReady,
      input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             ALUOp, RegW, MemW, Branch, Fault, State
   );
endinterface

// File: rtl/multicycle_main_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_main_fsm
// Main sequencing FSM of the multicycle ARM core. One ALU and one unified
// memory are reused across several cycles per instruction.
//   CLK      : clock, all state updates on the rising edge
//   Reset    : synchronous, active-high reset
//   bus      : multicycle_main_fsm_if.master (Op/Funct/MemReady in,
//              datapath enables, mux selects, Fault and State out)
// Parameters:
//   WAIT_LIMIT : max cycles waiting on MemReady in a memory state (0 = off);
//                must be < 2**CNT_W
//   CNT_W      : wait counter width
// Mux selects are registered from the next state; write strobes and Fault
// are combinational so they can be qualified by MemReady, the timeout and
// Reset in the cycle they apply to.
// -----------------------------------------------------------------------------
module multicycle_main_fsm #(
   parameter int unsigned WAIT_LIMIT = 0,
   parameter int unsigned CNT_W      = 8
) (
   input  logic CLK,
   input  logic Reset,
   multicycle_main_fsm_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECR   = 4'd6,
      EXECI   = 4'd7,
      ALUWB   = 4'd8,
      BRANCH  = 4'd9,
      UNKNOWN = 4'd10
   } state_t;

   typedef struct packed {
      logic       adr;
      logic       asa;
      logic [1:0] asb;
      logic [1:0] rs;
      logic       aluop;
      logic       regw;
      logic       memw;
      logic       br;
   } ctrl_t;

   // Per-state Moore control word; anything not set stays 0.
   function automatic ctrl_t dec(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH, DECODE: begin
            c.asa = 1'b1;
            c.asb = 2'b10;
            c.rs  = 2'b10;
         end
         MEMADR: c.asb = 2'b01;
         MEMRD:  c.adr = 1'b1;
         MEMWB: begin
            c.rs   = 2'b01;
            c.regw = 1'b1;
         end
         MEMWR: begin
            c.adr  = 1'b1;
            c.memw = 1'b1;
         end
         EXECR: c.aluop = 1'b1;
         EXECI: begin
            c.asb   = 2'b01;
            c.aluop = 1'b1;
         end
         ALUWB: c.regw = 1'b1;
         BRANCH: begin
            c.asb = 2'b01;
            c.rs  = 2'b10;
            c.br  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t           state;
   state_t           nxt;
   ctrl_t            ctl;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             mem_st;
   logic             timeout;

   always_comb begin
      mem_st  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
      timeout = (WAIT_LIMIT != 0) && mem_st && !bus.MemReady &&
                (cnt == CNT_W'(WAIT_LIMIT));

      nxt = FETCH;
      case (state)
         FETCH:  nxt = bus.MemReady ? DECODE : FETCH;
         DECODE: begin
            case (bus.Op)
               2'b00:   nxt = bus.Funct[5] ? EXECI : EXECR;
               2'b01:   nxt = MEMADR;
               2'b10:   nxt = BRANCH;
               default: nxt = UNKNOWN;
            endcase
         end
         MEMADR: nxt = bus.Funct[0] ? MEMRD : MEMWR;
         MEMRD:  nxt = bus.MemReady ? MEMWB : MEMRD;
         MEMWR:  nxt = bus.MemReady ? FETCH : MEMWR;
         EXECR,
         EXECI:  nxt = ALUWB;
         // MEMWB, ALUWB, BRANCH, UNKNOWN and illegal codes all return to FETCH
         default: nxt = FETCH;
      endcase
      // An aborted access always restarts at FETCH (including FETCH itself)
      if (timeout) nxt = FETCH;

      // Counting only happens while stalled in a memory state; every other
      // path (completion, leaving, timeout) zeroes it, which also covers
      // "cleared on entry" since non-memory states hold it at 0.
      cnt_nxt = '0;
      if (mem_st && !bus.MemReady && !timeout)
         cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= FETCH;
         cnt   <= '0;
         ctl   <= dec(FETCH);
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
         ctl   <= dec(nxt);
      end
   end

   // Strobes are masked by Reset so nothing is written in a reset cycle even
   // though the state register still holds the interrupted state.
   assign bus.IRWrite   = (state == FETCH) && bus.MemReady && !Reset;
   assign bus.NextPC    = (state == FETCH) && bus.MemReady && !Reset;
   assign bus.AdrSrc    = ctl.adr;
   assign bus.ALUSrcA   = ctl.asa;
   assign bus.ALUSrcB   = ctl.asb;
   assign bus.ResultSrc = ctl.rs;
   assign bus.ALUOp     = ctl.aluop;
   assign bus.RegW      = ctl.regw && !Reset;
   assign bus.MemW      = ctl.memw && !timeout && !Reset;
   assign bus.Branch    = ctl.br && !Reset;
   assign bus.Fault     = !Reset && ((state == UNKNOWN) || timeout);
   assign bus.State     = state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
module tb_multicycle_main_fsm;
   localparam int LIM = 4;

   logic CLK   = 1'b0;
   logic Reset = 1'b1;

   multicycle_main_fsm_if bus();

   multicycle_main_fsm #(.WAIT_LIMIT(LIM), .CNT_W(8)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] st;
      logic       irw;
      logic       npc;
      logic       adr;
      logic       asa;
      logic [1:0] asb;
      logic [1:0] rs;
      logic       aluop;
      logic       regw;
      logic       memw;
      logic       br;
      logic       fault;
   } obs_t;

   obs_t       q[$];
   int         ntests = 0;
   int         nfail  = 0;
   int         ncyc   = 0;
   logic [1:0] cur_op;
   logic [5:0] cur_funct;

   // Expected outputs of a state when nothing special (completion, timeout,
   // reset) happens in that cycle, straight from the state table.
   function automatic obs_t base(input int s);
      obs_t e;
      e    = '0;
      e.st = 4'(s);
      case (s)
         0, 1: begin e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; end
         2:    e.asb = 2'b01;
         3:    e.adr = 1;
         4:    begin e.rs = 2'b01; e.regw = 1; end
         5:    begin e.adr = 1; e.memw = 1; end
         6:    e.aluop = 1;
         7:    begin e.asb = 2'b01; e.aluop = 1; end
         8:    e.regw = 1;
         9:    begin e.asb = 2'b01; e.rs = 2'b10; e.br = 1; end
         10:   e.fault = 1;
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic chk(input logic ok, input string what);
      ntests++;
      if (ok !== 1'b1) begin
         nfail++;
         $display("FAIL %s: st=%0d MemW=%b Fault=%b IRWrite=%b NextPC=%b",
                  what, bus.State, bus.MemW, bus.Fault, bus.IRWrite, bus.NextPC);
      end
   endtask

   // One clock cycle: apply inputs, queue the expected outputs for it.
   task automatic cyc(input logic r, input logic mr, input obs_t e);
      Reset        = r;
      bus.Op       = cur_op;
      bus.Funct    = cur_funct;
      bus.MemReady = mr;
      q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // Whole instruction: fw fetch stall cycles, mw data-access stall cycles.
   task automatic do_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int fw, input int mw);
      obs_t e;
      int   c;
      int   s;
      cur_op    = op;
      cur_funct = funct;
      c = 0;
      for (int k = 0; k < fw; k++) begin
         if (LIM > 0 && c == LIM) begin
            e = base(0); e.fault = 1;
            cyc(0, 0, e);
            c = 0;
         end else begin
            cyc(0, 0, base(0));
            c++;
         end
      end
      e = base(0); e.irw = 1; e.npc = 1;
      cyc(0, 1, e);
      cyc(0, rnd(), base(1));
      case (op)
         2'b00: begin
            cyc(0, rnd(), base(funct[5] ? 7 : 6));
            cyc(0, rnd(), base(8));
         end
         2'b01: begin
            cyc(0, rnd(), base(2));
            s = funct[0] ? 3 : 5;
            c = 0;
            for (int k = 0; k < mw; k++) begin
               if (LIM > 0 && c == LIM) begin
                  e = base(s); e.memw = 0; e.fault = 1;
                  cyc(0, 0, e);
                  return;
               end
               cyc(0, 0, base(s));
               c++;
            end
            cyc(0, 1, base(s));
            if (s == 3) cyc(0, rnd(), base(4));
         end
         2'b10: cyc(0, rnd(), base(9));
         default: cyc(0, rnd(), base(10));
      endcase
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectation.
   always @(negedge CLK) begin : mon
      obs_t e;
      obs_t g;
      if (q.size() > 0) begin
         e = q.pop_front();
         g = {bus.State, bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA,
              bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.RegW, bus.MemW,
              bus.Branch, bus.Fault};
         ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL outputs cyc %0d: got st=%0d vec=%05h, expected st=%0d vec=%05h",
                     ncyc, g.st, g, e.st, e);
         end
         ncyc++;
      end
   end

   initial begin
      obs_t e;
      cur_op       = 2'b00;
      cur_funct    = 6'b0;
      bus.Op       = 2'b00;
      bus.Funct    = 6'b0;
      bus.MemReady = 1'b0;
      Reset        = 1'b1;
      @(posedge CLK);
      #1;
      // still in reset with MemReady high: no fetch strobe
      cyc(1, 1, base(0));

      do_instr(2'b00, 6'b001000, 0, 0);   // ADD reg
      do_instr(2'b00, 6'b101000, 0, 0);   // ADD imm
      do_instr(2'b01, 6'b011001, 0, 3);   // LDR, 3 stalls
      do_instr(2'b01, 6'b011000, 0, 2);   // STR, 2 stalls
      do_instr(2'b10, 6'b000000, 0, 0);   // B
      do_instr(2'b11, 6'b010101, 0, 0);   // undefined
      do_instr(2'b00, 6'b001000, 10, 0);  // fetch timeout twice
      do_instr(2'b01, 6'b000001, 0, 5);   // MEMRD timeout
      do_instr(2'b01, 6'b000000, 0, 6);   // MEMWR timeout
      do_instr(2'b01, 6'b000001, 3, 4);   // one cycle short of timeout

      // Reset mid-MEMWR with memory stalled
      cur_op = 2'b01; cur_funct = 6'b000000;
      e = base(0); e.irw = 1; e.npc = 1;
      cyc(0, 1, e);
      cyc(0, 0, base(1));
      cyc(0, 0, base(2));
      cyc(0, 0, base(5));
      e = base(5); e.memw = 0;
      cyc(1, 0, e);
      cyc(1, 0, base(0));
      chk(bus.State == 4'd0 && bus.MemW == 1'b0 && bus.Fault == 1'b0,
          "reset state");

      // Expired wait in FETCH
      for (int k = 0; k < LIM; k++)
         cyc(0, 0, base(0));
      Reset        = 1'b0;
      bus.MemReady = 1'b0;
      #1;
      chk(bus.State == 4'd0 && bus.Fault == 1'b1 && bus.IRWrite == 1'b0 &&
          bus.NextPC == 1'b0, "expired wait");
      e = base(0); e.fault = 1;
      cyc(0, 0, e);

      do_instr(2'b00, 6'b001000, 1, 0);

      for (int i = 0; i < 80; i++)
         do_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                  $urandom_range(0, 6), $urandom_range(0, 6));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
